// File: rtl/c17_pkg.sv
// c17_pkg: shared definitions for the pipelined c17 evaluator.
//   STAGES_MIN / STAGES_MAX : legal range of the pipeline depth parameter
//   c17_eval                : single-lane reference evaluation of the c17 netlist,
//                             returns {N22, N23}; apply per bit for any WIDTH
package c17_pkg;

    localparam int unsigned STAGES_MIN = 1;
    localparam int unsigned STAGES_MAX = 3;

    // Full c17 NAND network for one lane.
    function automatic logic [1:0] c17_eval(
        input logic n1,
        input logic n2,
        input logic n3,
        input logic n6,
        input logic n7
    );
        logic n10, n11, n16, n19;
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

endpackage

// File: rtl/c17_stage_reg.sv
// c17_stage_reg: one pipeline rank (data word plus valid bit).
//   clk, rst   : clock, asynchronous active-high reset (clears data and valid)
//   en_i       : load enable (global advance)
//   clr_i      : synchronous valid clear, takes priority over en_i
//   valid_i    : valid bit from the predecessor rank
//   d_i        : data word from the predecessor rank
//   valid_o    : registered valid
//   q_o        : registered data
module c17_stage_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         valid_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Valid bit: flush wins over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
        end
    end

    // Data word: contents are don't-care while invalid, so flush is ignored here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/c17_pipe.sv
// c17_pipe: WIDTH independent c17 lanes with a valid/ready pipeline of
// STAGES register ranks (1..3), global stall, synchronous flush and
// registered outputs.
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : clears every valid bit at the next edge; blocks input
//   in_valid / in_ready : input handshake (in_ready is combinational)
//   n1,n2,n3,n6,n7      : c17 inputs, lane i on bit i
//   out_valid/out_ready : output handshake
//   n22, n23            : registered c17 outputs, lane i on bit i
module c17_pipe
    import c17_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n1,
    input  logic [WIDTH-1:0] n2,
    input  logic [WIDTH-1:0] n3,
    input  logic [WIDTH-1:0] n6,
    input  logic [WIDTH-1:0] n7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] n22,
    output logic [WIDTH-1:0] n23
);

    // Rank payload widths: A = {N10, N11, N2, N7}, B = {N16, N19, N10}, out = {N22, N23}.
    localparam int unsigned AW = 4 * WIDTH;
    localparam int unsigned BW = 3 * WIDTH;
    localparam int unsigned OW = 2 * WIDTH;

    logic          advance;
    logic          out_vd;
    logic [OW-1:0] out_d;
    logic [OW-1:0] out_q;

    // Single global stall: every rank moves only when the output slot frees up.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    if (WIDTH < 1) begin : g_bad_width
        $error("c17_pipe: WIDTH must be at least 1");
    end

    case (STAGES)
        1: begin : g_s1
            // Output rank sees the whole netlist.
            always_comb begin
                out_d = '0;
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    {out_d[WIDTH + i], out_d[i]} = c17_eval(n1[i], n2[i], n3[i], n6[i], n7[i]);
                end
            end
            assign out_vd = in_valid;
        end

        2: begin : g_s2
            logic [AW-1:0]    a_d;
            logic [AW-1:0]    a_q;
            logic             a_vq;
            logic [WIDTH-1:0] a_n10, a_n11, a_n2, a_n7;
            logic [WIDTH-1:0] n16_c, n19_c;

            assign a_d = {~(n1 & n3), ~(n3 & n6), n2, n7};

            c17_stage_reg #(.W(AW)) u_rank_a (
                .clk     (clk),
                .rst     (rst),
                .en_i    (advance),
                .clr_i   (flush),
                .valid_i (in_valid),
                .d_i     (a_d),
                .valid_o (a_vq),
                .q_o     (a_q)
            );

            assign {a_n10, a_n11, a_n2, a_n7} = a_q;

            // Second half of the netlist feeds the output rank.
            always_comb begin
                n16_c = ~(a_n2 & a_n11);
                n19_c = ~(a_n11 & a_n7);
                out_d = {~(a_n10 & n16_c), ~(n16_c & n19_c)};
            end
            assign out_vd = a_vq;
        end

        3: begin : g_s3
            logic [AW-1:0]    a_d;
            logic [AW-1:0]    a_q;
            logic             a_vq;
            logic [BW-1:0]    b_d;
            logic [BW-1:0]    b_q;
            logic             b_vq;
            logic [WIDTH-1:0] a_n10, a_n11, a_n2, a_n7;
            logic [WIDTH-1:0] b_n16, b_n19, b_n10;

            assign a_d = {~(n1 & n3), ~(n3 & n6), n2, n7};

            c17_stage_reg #(.W(AW)) u_rank_a (
                .clk     (clk),
                .rst     (rst),
                .en_i    (advance),
                .clr_i   (flush),
                .valid_i (in_valid),
                .d_i     (a_d),
                .valid_o (a_vq),
                .q_o     (a_q)
            );

            assign {a_n10, a_n11, a_n2, a_n7} = a_q;

            // Middle layer: N16, N19 and N10 carried forward.
            assign b_d = {~(a_n2 & a_n11), ~(a_n11 & a_n7), a_n10};

            c17_stage_reg #(.W(BW)) u_rank_b (
                .clk     (clk),
                .rst     (rst),
                .en_i    (advance),
                .clr_i   (flush),
                .valid_i (a_vq),
                .d_i     (b_d),
                .valid_o (b_vq),
                .q_o     (b_q)
            );

            assign {b_n16, b_n19, b_n10} = b_q;

            assign out_d  = {~(b_n10 & b_n16), ~(b_n16 & b_n19)};
            assign out_vd = b_vq;
        end

        default: begin : g_bad_stages
            $error("c17_pipe: STAGES must be in [%0d,%0d]", STAGES_MIN, STAGES_MAX);
        end
    endcase

    // Output rank: n22/n23 and out_valid come straight from flops.
    c17_stage_reg #(.W(OW)) u_rank_out (
        .clk     (clk),
        .rst     (rst),
        .en_i    (advance),
        .clr_i   (flush),
        .valid_i (out_vd),
        .d_i     (out_d),
        .valid_o (out_valid),
        .q_o     (out_q)
    );

    assign n22 = out_q[OW-1:WIDTH];
    assign n23 = out_q[WIDTH-1:0];

endmodule

// File: tb/tb_c17_pipe.sv
// tb_c17_pipe: three c17_pipe instances (STAGES = 1, 2, 3) share one stimulus
// stream; each has its own scoreboard queue filled on acceptance and drained
// by a negedge monitor on every output handshake.
module tb_c17_pipe;
    import c17_pkg::*;

    localparam int unsigned W  = 8;
    localparam int          NI = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] n1, n2, n3, n6, n7;

    logic         in_ready_a  [NI];
    logic         out_valid_a [NI];
    logic [W-1:0] n22_a       [NI];
    logic [W-1:0] n23_a       [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        c17_pipe #(.WIDTH(W), .STAGES(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready_a[g]),
            .n1        (n1),
            .n2        (n2),
            .n3        (n3),
            .n6        (n6),
            .n7        (n7),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready),
            .n22       (n22_a[g]),
            .n23       (n23_a[g])
        );
    end

    typedef struct {
        logic [W-1:0] e22;
        logic [W-1:0] e23;
        int           acc_cyc;
        bit           lat;
    } exp_t;

    exp_t sb [NI][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] drv_e22, drv_e23;
    bit           drv_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference in sum-of-products form: N22 = N1N3 + N2~(N3N6), N23 = ~(N3N6)(N2+N7).
    function automatic void model(input logic [W-1:0] a1, a2, a3, a6, a7,
                                  output logic [W-1:0] r22, r23);
        r22 = (a1 & a3) | (a2 & ~(a3 & a6));
        r23 = ~(a3 & a6) & (a2 | a7);
    endfunction

    // Monitor / scoreboard
    logic [W-1:0] prev22 [NI];
    logic [W-1:0] prev23 [NI];
    bit           prev_stall [NI];
    bit           prev_flush;
    exp_t         pe;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                sb[i].delete();
                prev_stall[i] = 1'b0;
            end
            prev_flush = 1'b0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("s%0d_in_ready", i + 1), 64'(in_ready_a[i]),
                      64'(!out_valid_a[i] || out_ready));
                if (prev_flush)
                    check($sformatf("s%0d_valid_after_flush", i + 1), 64'(out_valid_a[i]), 64'(0));
                if (prev_stall[i]) begin
                    check($sformatf("s%0d_stall_valid_held", i + 1), 64'(out_valid_a[i]), 64'(1));
                    check($sformatf("s%0d_stall_n22_held", i + 1), 64'(n22_a[i]), 64'(prev22[i]));
                    check($sformatf("s%0d_stall_n23_held", i + 1), 64'(n23_a[i]), 64'(prev23[i]));
                end
                if (out_valid_a[i] && out_ready) begin
                    if (sb[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL s%0d_unexpected_output n22=%0h n23=%0h required=none (t=%0t)",
                                 i + 1, n22_a[i], n23_a[i], $time);
                    end else begin
                        pe = sb[i].pop_front();
                        check($sformatf("s%0d_n22", i + 1), 64'(n22_a[i]), 64'(pe.e22));
                        check($sformatf("s%0d_n23", i + 1), 64'(n23_a[i]), 64'(pe.e23));
                        if (pe.lat)
                            check($sformatf("s%0d_latency", i + 1), 64'(cyc - pe.acc_cyc), 64'(i + 1));
                    end
                end
                if (flush)
                    sb[i].delete();
                else if (in_valid && in_ready_a[i])
                    sb[i].push_back('{drv_e22, drv_e23, cyc, drv_lat});
                prev_stall[i] = out_valid_a[i] && !out_ready && !flush;
                prev22[i]     = n22_a[i];
                prev23[i]     = n23_a[i];
            end
            prev_flush = flush;
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic send(input bit v, input bit lat);
        logic [W-1:0] r22, r23;
        n1 = W'($urandom());
        n2 = W'($urandom());
        n3 = W'($urandom());
        n6 = W'($urandom());
        n7 = W'($urandom());
        in_valid = v;
        model(n1, n2, n3, n6, n7, r22, r23);
        drv_e22 = r22;
        drv_e23 = r23;
        drv_lat = lat;
        @(posedge clk);
        #1;
    endtask

    task automatic send_dir(input logic [W-1:0] a1, a2, a3, a6, a7,
                            input logic [W-1:0] e22, e23);
        n1 = a1; n2 = a2; n3 = a3; n6 = a6; n7 = a7;
        in_valid = 1'b1;
        drv_e22  = e22;
        drv_e23  = e23;
        drv_lat  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit sb_empty();
        return sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0;
    endfunction

    task automatic drain();
        int t = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (t < 50 && !sb_empty()) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (!sb_empty()) begin
            errors++;
            $display("FAIL drain pending=%0d/%0d/%0d required=0", sb[0].size(), sb[1].size(), sb[2].size());
        end
        idle(3);
    endtask

    initial begin
        logic [4:0]   b;
        logic [1:0]   pk;
        logic [W-1:0] r22, r23;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n1 = '0; n2 = '0; n3 = '0; n6 = '0; n7 = '0;
        drv_e22 = '0; drv_e23 = '0; drv_lat = 1'b0;

        // Package helper against the bench model, all 32 lane combinations.
        for (int v = 0; v < 32; v++) begin
            b  = 5'(v);
            pk = c17_eval(b[0], b[1], b[2], b[3], b[4]);
            model({W{b[0]}}, {W{b[1]}}, {W{b[2]}}, {W{b[3]}}, {W{b[4]}}, r22, r23);
            check($sformatf("c17_eval_%0d", v), 64'(pk), 64'({r22[0], r23[0]}));
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("s%0d_rst_valid", i + 1), 64'(out_valid_a[i]), 64'(0));
            check($sformatf("s%0d_rst_n22", i + 1), 64'(n22_a[i]), 64'(0));
            check($sformatf("s%0d_rst_n23", i + 1), 64'(n23_a[i]), 64'(0));
            check($sformatf("s%0d_rst_in_ready", i + 1), 64'(in_ready_a[i]), 64'(1));
        end
        rst = 1'b0;
        idle(2);

        // Single all-ones vector: N22=1, N23=0 on every lane, exact latency.
        send_dir('1, '1, '1, '1, '1, 8'hFF, 8'h00);
        idle(5);

        // Lane independence: lane0 zeros, lane1 n1=n3, lane2 n2=n7, lane3 all ones.
        send_dir(8'b0000_1010, 8'b0000_1100, 8'b0000_1010, 8'b0000_1000, 8'b0000_1100,
                 8'b0000_1110, 8'b0000_0100);
        idle(5);

        // Back-to-back streaming at full rate.
        repeat (32) send(1'b1, 1'b1);
        drain();

        // Stall with results pending, random input offers during the stall.
        repeat (4) send(1'b1, 1'b0);
        out_ready = 1'b0;
        repeat (5) send(1'($urandom_range(0, 1)), 1'b0);
        out_ready = 1'b1;
        repeat (6) send(1'($urandom_range(0, 1)), 1'b0);
        drain();

        // Flush with vectors in flight; second flush cycle has in_ready=1.
        out_ready = 1'b0;
        repeat (3) send(1'b1, 1'b0);
        flush = 1'b1;
        send(1'b1, 1'b0);
        out_ready = 1'b1;
        send(1'b1, 1'b0);
        flush = 1'b0;
        send(1'b1, 1'b1);
        drain();

        // Asynchronous reset between edges while full and stalled.
        out_ready = 1'b0;
        repeat (5) send(1'b1, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < NI; i++)
            check($sformatf("s%0d_full_before_rst", i + 1), 64'(out_valid_a[i]), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("s%0d_arst_valid", i + 1), 64'(out_valid_a[i]), 64'(0));
            check($sformatf("s%0d_arst_n22", i + 1), 64'(n22_a[i]), 64'(0));
            check($sformatf("s%0d_arst_n23", i + 1), 64'(n23_a[i]), 64'(0));
            check($sformatf("s%0d_arst_in_ready", i + 1), 64'(in_ready_a[i]), 64'(1));
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) send(1'b1, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
